// File: rtl/m_btb_ctrl_pkg.sv
// Shared BTB geometry, entry layout and helper types for the BTB update
// controller and its update FIFO.
package m_btb_ctrl_pkg;

    localparam int BTB_ENTRIES = 32;
    localparam int BTB_IDX_W   = 5;
    localparam int BTB_TAG_W   = 25;
    localparam int BTB_ENT_W   = 58;

    // Entry field positions: {valid, tag, target}
    localparam int BTB_V_BIT   = 57;
    localparam int BTB_TAG_HI  = 56;
    localparam int BTB_TAG_LO  = 32;
    localparam int BTB_DATA_HI = 31;
    localparam int BTB_DATA_LO = 0;

    // PC slices: index is pc[6:2], tag is pc[31:7]
    localparam int PC_IDX_LO   = 2;
    localparam int PC_TAG_LO   = 7;

    // Sweep counter carries one extra bit so "all entries written" is its MSB
    localparam int SWEEP_IDX_W = $clog2(BTB_ENTRIES) + 1;

    typedef logic [BTB_IDX_W-1:0] btb_idx_t;
    typedef logic [BTB_TAG_W-1:0] btb_tag_t;
    typedef logic [BTB_ENT_W-1:0] btb_ent_t;

    typedef struct packed {
        btb_idx_t idx;
        btb_ent_t ent;
    } btb_upd_t;

    typedef enum logic {
        ST_SWEEP = 1'b0,
        ST_RUN   = 1'b1
    } ctrl_state_e;

    function automatic btb_ent_t mk_entry(input logic v, input btb_tag_t tag,
                                          input logic [31:0] data);
        btb_ent_t e;
        e = '0;
        e[BTB_V_BIT]                 = v;
        e[BTB_TAG_HI:BTB_TAG_LO]     = tag;
        e[BTB_DATA_HI:BTB_DATA_LO]   = data;
        return e;
    endfunction

endpackage

// File: rtl/m_btb_ctrl_upd_fifo.sv
// Synchronous FIFO of pending BTB write operations {index, entry}.
// A single clear input empties it (used for both reset and flush).
module m_btb_upd_fifo
    import m_btb_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     clr,
    input  logic     push,
    input  btb_upd_t push_data,
    input  logic     pop,
    output btb_upd_t pop_data,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    btb_upd_t        mem_q [DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [AW:0]     cnt_q,  cnt_d;
    logic            push_ok, pop_ok;

    assign full     = (cnt_q == CNT_FULL);
    assign empty    = (cnt_q == '0);
    assign push_ok  = push & ~full;
    assign pop_ok   = pop & ~empty;
    assign pop_data = mem_q[rptr_q];

    // Pointer and occupancy update; pointers wrap naturally at DEPTH
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (clr) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push_ok) wptr_d = wptr_q + AW'(1);
            if (pop_ok)  rptr_d = rptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   cnt_d = cnt_q + (AW+1)'(1);
                2'b01:   cnt_d = cnt_q - (AW+1)'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Control state register
    always_ff @(posedge clk) begin
        wptr_q <= wptr_d;
        rptr_q <= rptr_d;
        cnt_q  <= cnt_d;
    end

    // Storage write; contents are don't-care while empty so no clear needed
    always_ff @(posedge clk) begin
        if (push_ok && !clr) mem_q[wptr_q] <= push_data;
    end

endmodule

// File: rtl/m_btb_ctrl.sv
// BTB update controller: filters branch resolutions into insert/invalidate
// writes, queues them, drives the single BTB write port, and runs the
// invalidate-all sweep after reset and on flush.
// Optional build macro BTB_CTRL_STATS_EN adds insert/inval/skip counters.
module m_btb_ctrl
    import m_btb_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 w_clk,
    input  logic                 w_rst,
    input  logic                 w_req,
    output logic                 w_rdy,
    input  logic [31:0]          w_req_pc,
    input  logic [31:0]          w_req_tgt,
    input  logic                 w_req_taken,
    input  logic                 w_req_hit,
    input  logic                 w_flush,
    output logic                 w_busy,
    output logic                 w_we,
    output logic [BTB_IDX_W-1:0] w_wadr,
    output logic [BTB_ENT_W-1:0] w_wd
`ifdef BTB_CTRL_STATS_EN
    ,
    output logic [31:0]          w_cnt_ins,
    output logic [31:0]          w_cnt_inv,
    output logic [31:0]          w_cnt_skip
`endif
);

    ctrl_state_e              state_q, state_d;
    logic [SWEEP_IDX_W-1:0]   sweep_idx_q, sweep_idx_d;
    logic                     we_q, we_d;
    btb_idx_t                 wadr_q, wadr_d;
    btb_ent_t                 wd_q, wd_d;

    logic                     fifo_push, fifo_pop, fifo_clr;
    logic                     fifo_full, fifo_empty;
    btb_upd_t                 fifo_head;
    btb_upd_t                 req_upd;

    logic                     req_acc;
    logic                     op_ins, op_inv, op_skip, op_vld;
    btb_tag_t                 req_tag;
    btb_idx_t                 req_idx;
    logic                     unused_pc;

    assign unused_pc = ^w_req_pc[PC_IDX_LO-1:0];

    assign req_idx = w_req_pc[PC_IDX_LO +: BTB_IDX_W];
    assign req_tag = w_req_pc[PC_TAG_LO +: BTB_TAG_W];

    // Events presented during a flush are dropped, never enqueued or counted
    assign w_rdy   = (state_q == ST_RUN) & ~fifo_full;
    assign req_acc = w_req & w_rdy & ~w_flush;
    assign op_ins  = req_acc & w_req_taken;
    assign op_inv  = req_acc & ~w_req_taken & w_req_hit;
    assign op_skip = req_acc & ~w_req_taken & ~w_req_hit;
    assign op_vld  = op_ins | op_inv;

    assign req_upd.idx = req_idx;
    assign req_upd.ent = w_req_taken ? mk_entry(1'b1, req_tag, w_req_tgt)
                                     : mk_entry(1'b0, req_tag, 32'h0);

    assign fifo_clr = w_rst | w_flush;

    m_btb_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (w_clk),
        .clr       (fifo_clr),
        .push      (fifo_push),
        .push_data (req_upd),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Next state, write-port register inputs and FIFO handshake
    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        we_d        = 1'b0;
        wadr_d      = wadr_q;
        wd_d        = wd_q;
        fifo_push   = 1'b0;
        fifo_pop    = 1'b0;
        unique case (state_q)
            ST_SWEEP: begin
                if (w_flush) begin
                    sweep_idx_d = '0;
                end else if (!sweep_idx_q[SWEEP_IDX_W-1]) begin
                    we_d        = 1'b1;
                    wadr_d      = sweep_idx_q[BTB_IDX_W-1:0];
                    wd_d        = '0;
                    sweep_idx_d = sweep_idx_q + SWEEP_IDX_W'(1);
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Queued work goes first; an empty queue lets a new event
                // bypass straight onto the write port for one-cycle latency.
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    we_d      = 1'b1;
                    wadr_d    = fifo_head.idx;
                    wd_d      = fifo_head.ent;
                    fifo_push = op_vld;
                end else if (op_vld) begin
                    we_d   = 1'b1;
                    wadr_d = req_upd.idx;
                    wd_d   = req_upd.ent;
                end
                // The write popped this cycle still issues; the rest is dropped
                if (w_flush) begin
                    state_d     = ST_SWEEP;
                    sweep_idx_d = '0;
                end
            end
        endcase
    end

    // State and write-port registers; reset restarts the sweep
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state_q     <= ST_SWEEP;
            sweep_idx_q <= '0;
            we_q        <= 1'b0;
            wadr_q      <= '0;
            wd_q        <= '0;
        end else begin
            state_q     <= state_d;
            sweep_idx_q <= sweep_idx_d;
            we_q        <= we_d;
            wadr_q      <= wadr_d;
            wd_q        <= wd_d;
        end
    end

    assign w_busy = (state_q == ST_SWEEP);
    assign w_we   = we_q;
    assign w_wadr = wadr_q;
    assign w_wd   = wd_q;

`ifdef BTB_CTRL_STATS_EN
    logic [31:0] cnt_ins_q,  cnt_ins_d;
    logic [31:0] cnt_inv_q,  cnt_inv_d;
    logic [31:0] cnt_skip_q, cnt_skip_d;

    // Event counters; wrap at 2^32 and survive flush
    always_comb begin
        cnt_ins_d  = cnt_ins_q;
        cnt_inv_d  = cnt_inv_q;
        cnt_skip_d = cnt_skip_q;
        if (op_ins)  cnt_ins_d  = cnt_ins_q  + 32'd1;
        if (op_inv)  cnt_inv_d  = cnt_inv_q  + 32'd1;
        if (op_skip) cnt_skip_d = cnt_skip_q + 32'd1;
    end

    // Counter registers, cleared only by reset
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            cnt_ins_q  <= '0;
            cnt_inv_q  <= '0;
            cnt_skip_q <= '0;
        end else begin
            cnt_ins_q  <= cnt_ins_d;
            cnt_inv_q  <= cnt_inv_d;
            cnt_skip_q <= cnt_skip_d;
        end
    end

    assign w_cnt_ins  = cnt_ins_q;
    assign w_cnt_inv  = cnt_inv_q;
    assign w_cnt_skip = cnt_skip_q;
`endif

endmodule

// File: tb/tb_m_btb_ctrl.sv
// Testbench for m_btb_ctrl: directed vector table, hand-written sweep/flush/
// reset sequences, and randomized traffic against a queue-based model.
module tb_m_btb_ctrl;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, req, taken, hit, flush;
    logic [31:0] pc, tgt;
    logic        rdy, busy, we;
    logic [4:0]  wadr;
    logic [57:0] wd;
`ifdef BTB_CTRL_STATS_EN
    logic [31:0] cnt_ins, cnt_inv, cnt_skip;
`endif

    always #5 clk = ~clk;

    m_btb_ctrl #(.DEPTH(DEPTH)) dut (
        .w_clk       (clk),
        .w_rst       (rst),
        .w_req       (req),
        .w_rdy       (rdy),
        .w_req_pc    (pc),
        .w_req_tgt   (tgt),
        .w_req_taken (taken),
        .w_req_hit   (hit),
        .w_flush     (flush),
        .w_busy      (busy),
        .w_we        (we),
        .w_wadr      (wadr),
        .w_wd        (wd)
`ifdef BTB_CTRL_STATS_EN
        ,
        .w_cnt_ins   (cnt_ins),
        .w_cnt_inv   (cnt_inv),
        .w_cnt_skip  (cnt_skip)
`endif
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]  idx;
        logic [57:0] ent;
    } op_t;

    op_t         mq[$];
    bit          m_run;
    int          m_idx;
    logic        m_we;
    logic [4:0]  m_wadr;
    logic [57:0] m_wd;
    int unsigned m_ins, m_inv, m_skip;

    always @(posedge clk) begin
        op_t nop;
        bit  acc, have;
        if (rst) begin
            mq.delete();
            m_run = 0; m_idx = 0;
            m_we = 1'b0; m_wadr = '0; m_wd = '0;
            m_ins = 0; m_inv = 0; m_skip = 0;
        end else if (!m_run) begin
            if (flush) begin
                m_idx = 0; m_we = 1'b0;
            end else if (m_idx < 32) begin
                m_we = 1'b1; m_wadr = 5'(m_idx); m_wd = '0; m_idx++;
            end else begin
                m_we = 1'b0; m_run = 1;
            end
        end else begin
            acc  = req && (mq.size() < DEPTH) && !flush;
            have = 0;
            nop.idx = pc[6:2];
            if (acc && taken) begin
                nop.ent = {1'b1, pc[31:7], tgt}; have = 1; m_ins++;
            end else if (acc && hit) begin
                nop.ent = {1'b0, pc[31:7], 32'h0}; have = 1; m_inv++;
            end else begin
                nop.ent = '0;
                if (acc) m_skip++;
            end
            if (mq.size() > 0) begin
                op_t h;
                h = mq.pop_front();
                m_we = 1'b1; m_wadr = h.idx; m_wd = h.ent;
                if (have) mq.push_back(nop);
            end else if (have) begin
                m_we = 1'b1; m_wadr = nop.idx; m_wd = nop.ent;
            end else begin
                m_we = 1'b0;
            end
            if (flush) begin
                mq.delete(); m_run = 0; m_idx = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("busy", 64'(busy), 64'(!m_run));
        chk("rdy",  64'(rdy),  64'(m_run && (mq.size() < DEPTH)));
        chk("we",   64'(we),   64'(m_we));
        chk("wadr", 64'(wadr), 64'(m_wadr));
        chk("wd",   64'(wd),   64'(m_wd));
`ifdef BTB_CTRL_STATS_EN
        chk("cnt_ins",  64'(cnt_ins),  64'(m_ins));
        chk("cnt_inv",  64'(cnt_inv),  64'(m_inv));
        chk("cnt_skip", 64'(cnt_skip), 64'(m_skip));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic idle_inputs();
        req = 1'b0; taken = 1'b0; hit = 1'b0; flush = 1'b0;
        pc = '0; tgt = '0;
    endtask

    task automatic drive_ev(input logic [31:0] p, input logic [31:0] t,
                            input logic tk, input logic ht);
        req = 1'b1; pc = p; tgt = t; taken = tk; hit = ht;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        req;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        taken;
        logic        hit;
        logic        exp_we;
        logic [4:0]  exp_wadr;
        logic [57:0] exp_wd;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int  nw;
        bit  seen;

        vecs[0]  = '{1'b1, 32'h0000_1084, 32'h0000_2000, 1'b1, 1'b0, 1'b1, 5'd1,  {1'b1, 25'h21, 32'h0000_2000}};
        vecs[1]  = '{1'b1, 32'h0000_1084, 32'h0000_FFFF, 1'b0, 1'b1, 1'b1, 5'd1,  {1'b0, 25'h21, 32'h0}};
        vecs[2]  = '{1'b1, 32'h0000_3000, 32'h0000_1111, 1'b0, 1'b0, 1'b0, 5'd1,  {1'b0, 25'h21, 32'h0}};
        vecs[3]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 5'd1,  {1'b0, 25'h21, 32'h0}};
        vecs[4]  = '{1'b1, 32'h8000_007C, 32'hDEAD_BEEC, 1'b1, 1'b0, 1'b1, 5'd31, {1'b1, 25'h100_0000, 32'hDEAD_BEEC}};
        vecs[5]  = '{1'b1, 32'hFFFF_FF80, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 5'd0,  {1'b1, 25'h1FF_FFFF, 32'h0}};
        vecs[6]  = '{1'b1, 32'h0000_0004, 32'h1234_5678, 1'b1, 1'b0, 1'b1, 5'd1,  {1'b1, 25'h0, 32'h1234_5678}};
        vecs[7]  = '{1'b1, 32'h1234_5678, 32'h0000_0040, 1'b1, 1'b0, 1'b1, 5'd30, {1'b1, 25'h24_68AC, 32'h0000_0040}};
        vecs[8]  = '{1'b1, 32'h0000_1084, 32'h0000_3000, 1'b1, 1'b0, 1'b1, 5'd1,  {1'b1, 25'h21, 32'h0000_3000}};
        vecs[9]  = '{1'b1, 32'h0000_1084, 32'h0000_4000, 1'b1, 1'b0, 1'b1, 5'd1,  {1'b1, 25'h21, 32'h0000_4000}};
        vecs[10] = '{1'b1, 32'h0000_ABCD, 32'h0000_5555, 1'b0, 1'b0, 1'b0, 5'd1,  {1'b1, 25'h21, 32'h0000_4000}};
        vecs[11] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 5'd1,  {1'b1, 25'h21, 32'h0000_4000}};

        // Reset, then the 32-entry invalidate sweep
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_rdy",  64'(rdy),  64'd0);
        chk("rst_we",   64'(we),   64'd0);
        rst = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            tick();
            chk("sweep_we",   64'(we),   64'd1);
            chk("sweep_wadr", 64'(wadr), 64'(k - 1));
            chk("sweep_wd",   64'(wd),   64'd0);
            chk("sweep_busy", 64'(busy), 64'd1);
        end
        tick();
        chk("run_busy", 64'(busy), 64'd0);
        chk("run_rdy",  64'(rdy),  64'd1);
        chk("run_we",   64'(we),   64'd0);

        // Insert / invalidate / filter / back-to-back traffic
        for (int i = 0; i < 12; i++) begin
            chk("tbl_rdy", 64'(rdy), 64'd1);
            req = vecs[i].req; pc = vecs[i].pc; tgt = vecs[i].tgt;
            taken = vecs[i].taken; hit = vecs[i].hit;
            tick();
            chk("tbl_we",   64'(we),   64'(vecs[i].exp_we));
            chk("tbl_wadr", 64'(wadr), 64'(vecs[i].exp_wadr));
            chk("tbl_wd",   64'(wd),   64'(vecs[i].exp_wd));
        end
        idle_inputs();

        // Flush mid-traffic: the event in the flush cycle is dropped
        drive_ev(32'h0000_0108, 32'h0000_0A00, 1'b1, 1'b0);
        tick();
        chk("mt_ev1", 64'({we, wadr}), 64'({1'b1, 5'd2}));
        drive_ev(32'h0000_010C, 32'h0000_0B00, 1'b1, 1'b0);
        tick();
        chk("mt_ev2", 64'({we, wadr}), 64'({1'b1, 5'd3}));
        drive_ev(32'h0000_0110, 32'h0000_0C00, 1'b1, 1'b0);
        flush = 1'b1;
        tick();
        idle_inputs();
        chk("mt_drop_we", 64'(we),   64'd0);
        chk("mt_busy",    64'(busy), 64'd1);

        // Second flush at sweep index 10 restarts the sweep at index 0
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            if (we && wadr == 5'd10) seen = 1;
        end
        chk("reach_idx10", 64'(seen), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        nw = 0;
        for (int i = 0; i < 100 && busy; i++) begin
            tick();
            if (we) begin
                chk("restart_wadr", 64'(wadr), 64'(nw));
                nw++;
            end
        end
        chk("restart_writes", 64'(nw), 64'd32);
        chk("restart_done",   64'(busy), 64'd0);

        // Reset mid-sweep at index 20
        drive_ev(32'h0000_0020, 32'h0000_7000, 1'b0, 1'b0);
        tick();
        idle_inputs();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            if (we && wadr == 5'd20) seen = 1;
        end
        chk("reach_idx20", 64'(seen), 64'd1);
        rst = 1'b1;
        tick();
        chk("mrst_we", 64'(we), 64'd0);
`ifdef BTB_CTRL_STATS_EN
        chk("mrst_ins",  64'(cnt_ins),  64'd0);
        chk("mrst_skip", 64'(cnt_skip), 64'd0);
`endif
        rst = 1'b0;
        tick();
        chk("mrst_first_we",   64'(we),   64'd1);
        chk("mrst_first_wadr", 64'(wadr), 64'd0);
        for (int i = 0; i < 100 && busy; i++) tick();
        chk("mrst_done", 64'(busy), 64'd0);

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 3000; i++) begin
            req   = ($urandom_range(0, 3) != 0);
            pc    = (($urandom_range(0, 1) != 0) ? $urandom : {25'($urandom_range(0, 3)), 7'($urandom)});
            tgt   = $urandom;
            taken = $urandom_range(0, 1) != 0;
            hit   = $urandom_range(0, 1) != 0;
            flush = ($urandom_range(0, 149) == 0);
            rst   = ($urandom_range(0, 999) == 0);
            tick();
        end
        idle_inputs();
        rst = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/m_btb_ctrl.md
Name: m_btb_ctrl

Overview:
Update scheduler for the 32-entry direct-mapped branch target buffer (58-bit entries: valid, 25-bit tag, 32-bit target).
- Accepts branch-resolution events from EX and filters them into insert or invalidate operations.
- Buffers those operations in a small FIFO.
- Drives the BTB's single write port at most once per cycle.
- Owns the invalidate-all sweep used at reset and on fence.i/flush.

Parameters:
DEPTH, 4, update-FIFO entries; power of 2, minimum 2.

Ports:
w_clk  in  1  clock
w_rst  in  1  synchronous active-high reset
w_req  in  1  resolution event valid
w_rdy  out  1  controller can accept an event this cycle
w_req_pc  in  32  PC of the resolved branch
w_req_tgt  in  32  resolved target
w_req_taken  in  1  branch resolved taken
w_req_hit  in  1  BTB hit recorded at fetch for this branch
w_flush  in  1  invalidate-all request (level or pulse)
w_busy  out  1  sweep in progress
w_we  out  1  BTB write enable (registered)
w_wadr  out  5  BTB write index (registered)
w_wd  out  58  BTB write data {v, tag[24:0], data[31:0]} (registered)

Behaviour:
- Reset: queue emptied; state SWEEP, sweep index 0; w_we=0, w_wadr=0, w_wd=0, w_busy=1, w_rdy=0.
- Reset asserted mid-operation abandons everything and restarts the sweep at index 0.
- States:
  - SWEEP: w_rdy=0, w_busy=1.
    - One write per cycle: w_we=1, w_wadr=idx, w_wd=0; idx goes 0..31.
    - After idx 31 is written, go to RUN (exactly 32 write cycles).
    - The first write appears the cycle after reset or flush is seen.
  - RUN: w_busy=0, w_rdy = (count < DEPTH).
- Accept rule: an event is accepted when w_req & w_rdy.
- Filtering of accepted events:
  - taken: enqueue INSERT {1, pc[31:7], tgt}, index pc[6:2].
  - not taken & hit: enqueue INVAL {0, pc[31:7], 32'h0}, index pc[6:2].
  - not taken & no hit: consumes nothing; no write.
- Issue:
  - If the queue is non-empty in RUN, pop the head and register it onto w_we/w_wadr/w_wd for the next cycle.
  - Otherwise w_we=0; w_wadr and w_wd hold their last values.
- Latency: an event accepted into an empty queue in cycle N drives w_we=1 in cycle N+1. The BTB samples it at the end of N+1.
- Ordering: strict FIFO. Two events to the same index produce two writes in order, so the last one wins.
- Full: w_rdy=0; no same-cycle pass-through.
- Simultaneous enqueue and dequeue when 0<count<DEPTH: count unchanged.
- Pointers are log2(DEPTH) bits and wrap naturally.
- w_flush in RUN:
  - Queue is discarded; any event presented in the same cycle is dropped.
  - Enter SWEEP at idx 0.
  - A write registered in that same cycle still appears, as the final RUN write.
- w_flush during SWEEP: restart at idx 0.
- The controller never reads the BTB; the read path is untouched.

Optional Feature:
BTB_CTRL_STATS_EN:
- With the macro: adds outputs w_cnt_ins, w_cnt_inv and w_cnt_skip (32 bits each).
  - Counters increment on each INSERT enqueued, INVAL enqueued and filtered-out accepted event respectively.
  - Counters clear on w_rst only, not on flush, and wrap at 2^32.
- Without the macro: the ports and the logic are absent.

Decomposition:
- Shared header btb_defs.vh holds:
  - BTB_ENTRIES=32, BTB_IDX_W=5, BTB_TAG_W=25, BTB_ENT_W=58.
  - Field positions: valid bit 57, tag 56:32, data 31:0.
  - Index slice pc[6:2] and tag slice pc[31:7].
- Natural sub-module: m_btb_upd_fifo.
  - Synchronous FIFO of {idx5, entry58}, parameterised by DEPTH.
  - Exposes full/empty/push/pop.
  - Sync clear input used for both reset and flush.

Test Plan:
1. Reset: hold w_rst 2 cycles, release. Expect w_busy=1 and 32 consecutive writes, w_wadr 0..31 with w_wd=0. Then w_busy=0 and w_rdy=1 on cycle 33.
2. Insert: after the sweep, w_req with pc=0x0000_1084, tgt=0x0000_2000, taken=1. Next cycle expect w_we=1, w_wadr=0x01, w_wd={1, 25'h21, 32'h2000}; paired m_btb lookup at 0x1084 hits with dout 0x2000.
3. Invalidate/filter:
   - taken=0, hit=1, pc=0x1084: one write of w_wd={0, 25'h21, 0}.
   - taken=0, hit=0: no write, and w_cnt_skip+1 with stats enabled.
4. Full/backpressure, DEPTH=4: while issue is paused by a flush, w_rdy=0 for 32 cycles. Then 6 back-to-back taken events. w_rdy must never drop because a pop occurs every cycle; 6 writes appear in order.
5. Flush mid-traffic: 3 events queued, assert w_flush. At most 1 queued write is emitted; the other 2 are discarded. An event in the flush cycle is dropped. A full 32-write sweep follows, and a second w_flush at sweep idx 10 restarts it at idx 0.
6. Reset mid-sweep at idx 20: sweep restarts at idx 0 one cycle after release; queue empty; stats counters zero.
